// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester/consumer handshake bundle for mux8_rr_arbiter.
interface mux8_rr_arbiter_if;
  import mux8_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_lock;
  logic             out_ready;
  logic [SEL_W-1:0] select;
  logic [N_REQ-1:0] grant;
  logic             out_valid;
  logic             busy;

  // Arbiter side.
  modport master (
    input  req, req_lock, out_ready,
    output select, grant, out_valid, busy
  );

  // Requesters and downstream consumer.
  modport slave (
    output req, req_lock, out_ready,
    input  select, grant, out_valid, busy
  );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Round-robin pick: first set request bit searching from ptr upward, wrapping mod 8.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  always_comb begin
    dbl   = {req, req};
    rot   = dbl[ptr +: N_REQ];
    found = |req;
    off   = '0;
    // Descending scan so the lowest rotated bit wins.
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rot[i-1]) off = SEL_W'(i - 1);
    end
    idx = ptr + off;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for an 8-way 32-bit mux with capped locked bursts and valid/ready output.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned BEAT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               reset,
  mux8_rr_arbiter_if.master  arb
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic [SEL_W-1:0] sel_inc;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             cont;

  assign sel_inc = sel_q + 1'b1;
  // In BUSY the only pick consumed is the release re-pick, which starts just past the current owner.
  assign pick_ptr = (state_q == IDLE) ? ptr_q : sel_inc;

  rr_pick8 u_pick (
    .req   (arb.req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cont = arb.req_lock[sel_q] & arb.req[sel_q] & (beat_q < BEAT_W'(MAX_BURST));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          sel_d   = pick_idx;
          grant_d = onehot8(pick_idx);
          valid_d = 1'b1;
          beat_d  = BEAT_W'(1);
        end else begin
          sel_d   = '0;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (valid_q && arb.out_ready) begin
          if (cont) begin
            beat_d = beat_q + 1'b1;
          end else begin
            ptr_d = sel_inc;
            if (pick_found) begin
              sel_d   = pick_idx;
              grant_d = onehot8(pick_idx);
              valid_d = 1'b1;
              beat_d  = BEAT_W'(1);
            end else begin
              state_d = IDLE;
              sel_d   = '0;
              grant_d = '0;
              valid_d = 1'b0;
              beat_d  = '0;
            end
          end
        end else if (!arb.req[sel_q]) begin
          state_d = IDLE;
          ptr_d   = sel_inc;
          sel_d   = '0;
          grant_d = '0;
          valid_d = 1'b0;
          beat_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  assign arb.select    = sel_q;
  assign arb.grant     = grant_q;
  assign arb.out_valid = valid_q;
  assign arb.busy      = (state_q == BUSY);

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit 8-way mux datapath among 8 requesters.
- Drives the mux select and a one-hot grant.
- Presents a valid/ready handshake to the single downstream consumer.
- Supports locked multi-beat bursts, capped at MAX_BURST beats, so one requester cannot starve the others.

Parameters:
- MAX_BURST, 4: maximum consecutive beats granted to one locked requester before forced release. Legal range 1..16.
- BEAT_W, $clog2(MAX_BURST+1): width of the internal beat counter. Derived; do not override.

Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- req  in  8: request per requester; bit i = requester i.
- req_lock  in  8: requester i asks to keep the grant after its current beat.
- out_ready  in  1: downstream accepts the current beat.
- select  out  3: mux select; equals the index of the granted requester.
- grant  out  8: one-hot grant, or 0 when idle.
- out_valid  out  1: a beat is presented; the mux output is valid.
- busy  out  1: state is BUSY.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - state=IDLE, select=0, grant=0, out_valid=0, busy=0.
  - rr pointer ptr=0, beat_cnt=0.
- States: IDLE, BUSY. All outputs are registered.
- Pick function: first set bit of req, searching ptr, ptr+1, ..., ptr+7, wrapping mod 8.
- IDLE:
  - If req != 0: pick winner w. Next cycle: select=w, grant=1<<w, out_valid=1, beat_cnt=1, state=BUSY.
  - Latency: req sampled in cycle n gives grant visible in cycle n+1.
  - If req == 0: stay IDLE, outputs 0.
- BUSY, handshake (out_valid & out_ready):
  - Continue condition: req_lock[select] & req[select] & (beat_cnt < MAX_BURST).
    - If true: stay BUSY, keep select/grant, beat_cnt+1.
  - Otherwise release:
    - ptr = select+1 mod 8.
    - Re-pick from req using the new ptr, in the same cycle. The released requester therefore has lowest priority.
    - If a winner exists: load it next cycle, beat_cnt=1, stay BUSY. No bubble cycle between grants.
    - Else: grant=0, out_valid=0, state=IDLE.
- BUSY, no handshake, req[select] still high: hold all outputs unchanged (stall). out_valid never drops while stalled.
- BUSY, no handshake, req[select] low (withdraw): abort.
  - Next cycle: out_valid=0, grant=0, state=IDLE, ptr=select+1 mod 8.
  - No re-pick in the abort cycle.
- Forced release at MAX_BURST: a locked requester re-enters arbitration at lowest priority.
  - If it is the only requester, it is re-granted next cycle with beat_cnt=1 and no bubble.
- Changes to req or req_lock of non-granted requesters never affect the current grant.
- Reset asserted mid-burst: outputs clear immediately. The first grant after reset release comes from ptr=0.
- Invariants:
  - grant is one-hot or zero.
  - grant != 0 exactly when out_valid=1.
  - grant[select] = 1 whenever out_valid=1.

Decomposition:
- Package mux8_arb_pkg:
  - N_REQ=8, SEL_W=3.
  - Enum arb_state_t {IDLE, BUSY}.
- Sub-module rr_pick8, purely combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, idx[2:0].
  - Implementation: rotate, priority encode, un-rotate.
  - Instantiated once; used for both the IDLE pick and the release re-pick.

Test Plan:
- Single request: req=0x08, out_ready=1.
  - Cycle+1: select=3, grant=0x08, out_valid=1.
  - Cycle+2: if req=0, grant=0, IDLE, ptr=4.
- Full fairness: req=0xFF held, out_ready=1 from reset.
  - Grants 0,1,2,...,7,0 on consecutive cycles, no idle cycles, out_valid constantly 1.
- Burst cap: MAX_BURST=4; req=0x24, req_lock=0x04, out_ready=1.
  - Exactly 4 beats with select=2, then select=5 on the next cycle.
  - Afterwards requester 2 is re-granted only after 5 releases.
- Stall and withdraw:
  - req=0x02, out_ready=0 for 3 cycles: grant=0x02 held, out_valid=1 throughout.
  - Then drop req[1] with out_ready=0: next cycle out_valid=0, IDLE, ptr=2.
- Back-to-back handoff priority: ptr=6, req=0x41.
  - Grant goes to 6. On release, requester 0 is granted the next cycle even with req[6] still high.
- Reset mid-burst: assert reset during a locked beat 2 of requester 7.
  - grant=0, out_valid=0 immediately, before the next edge.
  - After release with req=0x81: requester 0 is granted first.
